// File: rtl/domain_pkg.sv
// Shared types and helpers for the execution domain.
// Holds the opcode encoding, FSM state encoding, decode helpers and the
// retired-instruction counter width.
package domain_pkg;

    localparam int INSN_CNT_W = 32;

    // Instruction opcodes (byte 0 of every instruction)
    typedef enum logic [7:0] {
        OP_NOP  = 8'h00,
        OP_LDI  = 8'h01,
        OP_ADDI = 8'h02,
        OP_SUBI = 8'h03,
        OP_ANDI = 8'h04,
        OP_ORI  = 8'h05,
        OP_XORI = 8'h06,
        OP_SHLI = 8'h07,
        OP_OUT  = 8'h08
    } op_e;

    // FSM state encoding; constants kept as plain localparams for older tools
    typedef logic [2:0] state_e;
    localparam state_e S_OP    = 3'd0;
    localparam state_e S_REG   = 3'd1;
    localparam state_e S_IMM   = 3'd2;
    localparam state_e S_EXEC  = 3'd3;
    localparam state_e S_FAULT = 3'd4;

    // Opcodes carrying an immediate field after the rd byte
    function automatic logic op_has_imm(input logic [7:0] op);
        return (op >= 8'h01) && (op <= 8'h07);
    endfunction

    // Opcodes this domain understands
    function automatic logic op_legal(input logic [7:0] op);
        return op <= 8'h08;
    endfunction

endpackage

// File: rtl/domain_regfile.sv
// Private register bank of the execution domain.
// NUM_REGS x REG_W entries, one asynchronous read port, one synchronous write
// port; synchronous reset clears every entry.
module domain_regfile #(
    parameter int REG_W    = 64,
    parameter int NUM_REGS = 64,
    parameter int RSEL_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [RSEL_W-1:0] raddr,
    output logic [REG_W-1:0]  rdata,
    input  logic              we,
    input  logic [RSEL_W-1:0] waddr,
    input  logic [REG_W-1:0]  wdata
);

    logic [REG_W-1:0] mem_q [NUM_REGS];
    logic [REG_W-1:0] mem_d [NUM_REGS];

    // Asynchronous read
    assign rdata = mem_q[raddr];

    // Next-state of the bank: single write port
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/exec_domain.sv
// Execution domain tile: decodes a byte-serial instruction stream and executes
// register-immediate ALU ops against a private register bank.
// Optional build macro EXEC_DOMAIN_FAULT_EN: illegal opcodes / nonzero high rd
// bits lock the tile in S_FAULT (fault=1, bus_ready=0) until reset. Without it,
// illegal opcodes retire as 1-byte NOPs and high rd bits are ignored.
//
// Handshake: a byte moves when bus_valid & bus_ready are both high at posedge;
// bus_ready depends only on FSM state, so a producer facing ready=0 simply
// holds its byte until a later edge.
module exec_domain
    import domain_pkg::*;
#(
    parameter int REG_W     = 64,
    parameter int NUM_REGS  = 64,
    parameter int IMM_BYTES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            bus_in,
    input  logic                  bus_valid,
    output logic                  bus_ready,
    output logic [REG_W-1:0]      result,
    output logic                  result_valid,
    output logic                  busy,
    output logic [INSN_CNT_W-1:0] insn_count,
    output logic                  fault
);

    localparam int RSEL_W = $clog2(NUM_REGS);
    localparam int SH_W   = $clog2(REG_W);
    localparam int CNT_W  = (IMM_BYTES > 1) ? $clog2(IMM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IMM = CNT_W'(IMM_BYTES - 1);

    state_e                  state_q, state_d;
    logic [7:0]              opcode_q, opcode_d;
    logic [RSEL_W-1:0]       rd_q, rd_d;
    logic [REG_W-1:0]        imm_q, imm_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [REG_W-1:0]        result_q, result_d;
    logic                    result_valid_q, result_valid_d;
    logic [INSN_CNT_W-1:0]   insn_count_q, insn_count_d;
    logic                    fault_q, fault_d;

    logic                    xfer;
    logic [REG_W-1:0]        rf_rdata;
    logic                    rf_we;
    logic [REG_W-1:0]        alu_out;
    logic                    opc_bad;
    logic                    rd_bad;

    assign bus_ready    = (state_q == S_OP) || (state_q == S_REG) || (state_q == S_IMM);
    assign xfer         = bus_valid && bus_ready;
    assign busy         = (state_q != S_OP);
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign insn_count   = insn_count_q;
    assign fault        = fault_q;

`ifdef EXEC_DOMAIN_FAULT_EN
    assign opc_bad = !op_legal(bus_in);
    assign rd_bad  = ((bus_in >> RSEL_W) != 8'h00);
`else
    assign opc_bad = 1'b0;
    assign rd_bad  = 1'b0;
`endif

    domain_regfile #(
        .REG_W    (REG_W),
        .NUM_REGS (NUM_REGS),
        .RSEL_W   (RSEL_W)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .raddr (rd_q),
        .rdata (rf_rdata),
        .we    (rf_we),
        .waddr (rd_q),
        .wdata (alu_out)
    );

    // Inline ALU: rd op imm, modulo 2^REG_W; reads the bank directly so an
    // instruction always sees the previous instruction's write
    always_comb begin
        alu_out = rf_rdata;
        case (op_e'(opcode_q))
            OP_LDI:  alu_out = imm_q;
            OP_ADDI: alu_out = rf_rdata + imm_q;
            OP_SUBI: alu_out = rf_rdata - imm_q;
            OP_ANDI: alu_out = rf_rdata & imm_q;
            OP_ORI:  alu_out = rf_rdata | imm_q;
            OP_XORI: alu_out = rf_rdata ^ imm_q;
            OP_SHLI: alu_out = rf_rdata << imm_q[SH_W-1:0];
            default: alu_out = rf_rdata;
        endcase
    end

    // Decode FSM, immediate assembly, retire and result update
    always_comb begin
        state_d        = state_q;
        opcode_d       = opcode_q;
        rd_d           = rd_q;
        imm_d          = imm_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        insn_count_d   = insn_count_q;
        fault_d        = fault_q;
        rf_we          = 1'b0;
        case (state_q)
            S_OP: begin
                if (xfer) begin
                    opcode_d = bus_in;
                    if (opc_bad) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else if (!op_legal(bus_in) || (bus_in == OP_NOP)) begin
                        // NOP (or tolerated illegal byte) retires right here
                        insn_count_d = insn_count_q + 1'b1;
                    end else begin
                        state_d = S_REG;
                    end
                end
            end
            S_REG: begin
                if (xfer) begin
                    if (rd_bad) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        rd_d    = bus_in[RSEL_W-1:0];
                        imm_d   = '0;
                        cnt_d   = '0;
                        state_d = op_has_imm(opcode_q) ? S_IMM : S_EXEC;
                    end
                end
            end
            S_IMM: begin
                if (xfer) begin
                    // little-endian: byte k lands in bits [8k+7:8k]
                    imm_d = imm_q | (REG_W'(bus_in) << {cnt_q, 3'b000});
                    if (cnt_q == LAST_IMM) begin
                        state_d = S_EXEC;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_EXEC: begin
                insn_count_d = insn_count_q + 1'b1;
                if (opcode_q == OP_OUT) begin
                    result_d       = rf_rdata;
                    result_valid_d = 1'b1;
                end else begin
                    rf_we = 1'b1;
                end
                state_d = S_OP;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_OP;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_OP;
            opcode_q       <= '0;
            rd_q           <= '0;
            imm_q          <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            insn_count_q   <= '0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            opcode_q       <= opcode_d;
            rd_q           <= rd_d;
            imm_q          <= imm_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            insn_count_q   <= insn_count_d;
            fault_q        <= fault_d;
        end
    end

endmodule

// File: tb/tb_exec_domain.sv
// Directed bench for exec_domain: a default 64-bit tile plus a small
// 16-bit / 4-register / 2-byte-immediate tile for the shift-masking case.
module tb_exec_domain;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [7:0]  bus_in = 8'h00;
    logic        bus_valid = 1'b0;
    logic        bus_ready;
    logic [63:0] result;
    logic        result_valid;
    logic        busy;
    logic [31:0] insn_count;
    logic        fault;

    logic [7:0]  bus_in2 = 8'h00;
    logic        bus_valid2 = 1'b0;
    logic        bus_ready2;
    logic [15:0] result2;
    logic        result_valid2;
    logic        busy2;
    logic [31:0] insn_count2;
    logic        fault2;

    int checks = 0;
    int errors = 0;
    int gap_max = 0;

    exec_domain #(.REG_W(64), .NUM_REGS(64), .IMM_BYTES(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus_in       (bus_in),
        .bus_valid    (bus_valid),
        .bus_ready    (bus_ready),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .insn_count   (insn_count),
        .fault        (fault)
    );

    exec_domain #(.REG_W(16), .NUM_REGS(4), .IMM_BYTES(2)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .bus_in       (bus_in2),
        .bus_valid    (bus_valid2),
        .bus_ready    (bus_ready2),
        .result       (result2),
        .result_valid (result_valid2),
        .busy         (busy2),
        .insn_count   (insn_count2),
        .fault        (fault2)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte (optionally after a random gap) and hold it until taken
    task automatic send_byte(input bit sel, input logic [7:0] b);
        int waited;
        int g;
        if (gap_max > 0) begin
            g = $urandom_range(0, gap_max);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
        end
        if (sel) begin bus_in2 = b; bus_valid2 = 1'b1; end
        else     begin bus_in  = b; bus_valid  = 1'b1; end
        @(negedge clk);
        waited = 0;
        while (!(sel ? bus_ready2 : bus_ready) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!(sel ? bus_ready2 : bus_ready)) begin
            check("ready_timeout", {63'd0, (sel ? bus_ready2 : bus_ready)}, 64'd1);
        end
        @(posedge clk);
        #1;
        if (sel) begin bus_valid2 = 1'b0; bus_in2 = 8'($urandom_range(0, 255)); end
        else     begin bus_valid  = 1'b0; bus_in  = 8'($urandom_range(0, 255)); end
    endtask

    // Send opcode, rd and nbytes of little-endian immediate; ends in S_EXEC
    task automatic send_insn(input bit sel, input logic [7:0] op, input logic [7:0] rd,
                             input logic [63:0] imm, input int nbytes);
        send_byte(sel, op);
        send_byte(sel, rd);
        for (int k = 0; k < nbytes; k++) begin
            send_byte(sel, imm[8*k +: 8]);
        end
    endtask

    // Immediate instruction on the 64-bit tile, waits out S_EXEC
    task automatic do_imm(input logic [7:0] op, input logic [7:0] rd, input logic [63:0] imm);
        send_insn(1'b0, op, rd, imm, 8);
        @(posedge clk);
        #1;
    endtask

    // OUT on the 64-bit tile with full timing checks of the result pulse
    task automatic do_out(input string tag, input logic [7:0] rd,
                          input logic [63:0] exp, input logic [31:0] exp_cnt);
        send_insn(1'b0, 8'h08, rd, 64'd0, 0);
        check({tag, "_exec_ready"}, {63'd0, bus_ready}, 64'd0);
        check({tag, "_exec_busy"}, {63'd0, busy}, 64'd1);
        check({tag, "_exec_rv"}, {63'd0, result_valid}, 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_result"}, result, exp);
        check({tag, "_rv"}, {63'd0, result_valid}, 64'd1);
        check({tag, "_count"}, {32'd0, insn_count}, {32'd0, exp_cnt});
        @(posedge clk);
        #1;
        check({tag, "_rv_drop"}, {63'd0, result_valid}, 64'd0);
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_result", result, 64'd0);
        check("rst_rv", {63'd0, result_valid}, 64'd0);
        check("rst_count", {32'd0, insn_count}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_ready", {63'd0, bus_ready}, 64'd1);
        check("rst_fault", {63'd0, fault}, 64'd0);

        // Test 1: LDI + OUT
        do_imm(8'h01, 8'd3, 64'h1122_3344_5566_7788);
        do_out("t1", 8'd3, 64'h1122_3344_5566_7788, 32'd2);

        // Test 2: wrap both ways
        do_imm(8'h01, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        do_imm(8'h02, 8'd0, 64'd1);
        do_out("t2_add", 8'd0, 64'd0, 32'd5);
        do_imm(8'h03, 8'd0, 64'd1);
        do_out("t2_sub", 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd7);

        // Logic ops and shift (68 masks to 4)
        do_imm(8'h01, 8'd7, 64'h0000_0000_0000_F0F0);
        do_imm(8'h04, 8'd7, 64'h0000_0000_0000_FF00);   // F000
        do_imm(8'h05, 8'd7, 64'h0000_0000_0000_000F);   // F00F
        do_imm(8'h06, 8'd7, 64'h0000_0000_0000_FFFF);   // 0FF0
        do_imm(8'h07, 8'd7, 64'd68);                    // FF00
        do_out("alu", 8'd7, 64'h0000_0000_0000_FF00, 32'd13);

        // NOP retires on acceptance
        send_byte(1'b0, 8'h00);
        check("nop_count", {32'd0, insn_count}, 64'd14);
        check("nop_busy", {63'd0, busy}, 64'd0);

        // Test 3: stalls mid-immediate, next opcode held across S_EXEC
        gap_max = 3;
        send_insn(1'b0, 8'h01, 8'd9, 64'hDEAD_BEEF_CAFE_F00D, 8);
        check("t3_exec_ready", {63'd0, bus_ready}, 64'd0);
        gap_max = 0;
        do_out("t3", 8'd9, 64'hDEAD_BEEF_CAFE_F00D, 32'd16);

        // Test 4: reset in the middle of an immediate
        do_imm(8'h01, 8'd5, 64'h1234);
        do_out("t4_pre", 8'd5, 64'h1234, 32'd18);
        send_byte(1'b0, 8'h01);
        send_byte(1'b0, 8'd5);
        send_byte(1'b0, 8'hAA);
        send_byte(1'b0, 8'hBB);
        send_byte(1'b0, 8'hCC);
        check("t4_mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t4_busy", {63'd0, busy}, 64'd0);
        check("t4_count", {32'd0, insn_count}, 64'd0);
        check("t4_result", result, 64'd0);
        do_out("t4_r5", 8'd5, 64'd0, 32'd1);

        // Test 5: illegal opcode / bad rd bits
        do_imm(8'h01, 8'd2, 64'h55);
`ifdef EXEC_DOMAIN_FAULT_EN
        send_byte(1'b0, 8'hFF);
        check("t5_fault", {63'd0, fault}, 64'd1);
        check("t5_ready", {63'd0, bus_ready}, 64'd0);
        check("t5_count", {32'd0, insn_count}, 64'd2);
        repeat (3) @(posedge clk);
        #1;
        check("t5_fault_hold", {63'd0, fault}, 64'd1);
        check("t5_count_hold", {32'd0, insn_count}, 64'd2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5_fault_clr", {63'd0, fault}, 64'd0);
        send_byte(1'b0, 8'h08);
        send_byte(1'b0, 8'h42);
        check("t5_rd_fault", {63'd0, fault}, 64'd1);
        check("t5_rd_count", {32'd0, insn_count}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
`else
        send_byte(1'b0, 8'hFF);
        check("t5_count", {32'd0, insn_count}, 64'd3);
        check("t5_busy", {63'd0, busy}, 64'd0);
        check("t5_fault", {63'd0, fault}, 64'd0);
        // rd 0x42 keeps only its low 6 bits -> r2
        do_out("t5_out", 8'h42, 64'h55, 32'd4);
        check("t5_fault_end", {63'd0, fault}, 64'd0);
`endif

        // Test 6: small tile, shift by 17 masks to 1
        send_insn(1'b1, 8'h01, 8'd1, 64'h0003, 2);
        @(posedge clk);
        #1;
        send_insn(1'b1, 8'h07, 8'd1, 64'd17, 2);
        @(posedge clk);
        #1;
        send_insn(1'b1, 8'h08, 8'd1, 64'd0, 0);
        check("t6_exec_ready", {63'd0, bus_ready2}, 64'd0);
        @(posedge clk);
        #1;
        check("t6_result", {48'd0, result2}, 64'h0006);
        check("t6_rv", {63'd0, result_valid2}, 64'd1);
        check("t6_count", {32'd0, insn_count2}, 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
